// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: ID forwarding selects, load-use stall,
// taken-branch kill and multi-cycle EXE freeze with a watchdog on the done handshake.
module pipeline_hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int RN_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RN_W-1:0] id_rs,
    input  logic [RN_W-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [RN_W-1:0] id_rn,
    input  logic            id_wreg,
    input  logic            id_m2reg,
    input  logic            id_mc,
    input  logic            exe_branch_taken,
    input  logic            mc_done,
    output logic            pc_we,
    output logic            ifid_we,
    output logic            idexe_we,
    output logic            ifid_flush,
    output logic            idexe_bubble,
    output logic            exemem_bubble,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb,
    output logic            mc_start,
    output logic            mc_err,
    output logic [15:0]     stall_cnt
);
    localparam int CW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(MC_TIMEOUT - 1);

    typedef enum logic {RUN, MC_WAIT} state_t;
    state_t state, state_next;

    logic [RN_W-1:0] e_rn, m_rn;
    logic            e_wreg, e_m2reg, e_mc;
    logic            m_wreg, m_m2reg;
    logic [CW-1:0]   wd_cnt;
    logic            lu, wd_expired, mc_exit;

    assign lu = id_valid && e_wreg && e_m2reg && (e_rn != '0) &&
                ((id_use_rs && (e_rn == id_rs)) || (id_use_rt && (e_rn == id_rt)));
    assign wd_expired = (wd_cnt == WD_LAST);
    assign mc_exit    = mc_done || wd_expired;

    // A load sitting in EXE is skipped here; the load-use stall holds the consumer instead.
    always_comb begin
        fwda = 2'b00;
        if (id_rs != '0) begin
            if (e_wreg && !e_m2reg && (e_rn == id_rs))
                fwda = 2'b01;
            else if (m_wreg && (m_rn == id_rs))
                fwda = m_m2reg ? 2'b11 : 2'b10;
        end
    end

    always_comb begin
        fwdb = 2'b00;
        if (id_rt != '0) begin
            if (e_wreg && !e_m2reg && (e_rn == id_rt))
                fwdb = 2'b01;
            else if (m_wreg && (m_rn == id_rt))
                fwdb = m_m2reg ? 2'b11 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (e_mc && !exe_branch_taken) state_next = MC_WAIT;
            MC_WAIT: if (mc_exit) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        idexe_we      = 1'b1;
        ifid_flush    = 1'b0;
        idexe_bubble  = 1'b0;
        exemem_bubble = 1'b0;
        mc_start      = 1'b0;
        case (state)
            RUN: begin
                if (exe_branch_taken) begin
                    ifid_flush   = 1'b1;
                    idexe_bubble = 1'b1;
                end else if (e_mc) begin
                    mc_start      = 1'b1;
                    pc_we         = 1'b0;
                    ifid_we       = 1'b0;
                    idexe_we      = 1'b0;
                    exemem_bubble = 1'b1;
                end else if (lu) begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idexe_bubble = 1'b1;
                end
            end
            MC_WAIT: begin
                if (!mc_exit) begin
                    pc_we         = 1'b0;
                    ifid_we       = 1'b0;
                    idexe_we      = 1'b0;
                    exemem_bubble = 1'b1;
                end else if (lu) begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idexe_bubble = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_rn    <= '0;
            e_wreg  <= 1'b0;
            e_m2reg <= 1'b0;
            e_mc    <= 1'b0;
        end else if (idexe_we) begin
            if (idexe_bubble || !id_valid) begin
                e_rn    <= '0;
                e_wreg  <= 1'b0;
                e_m2reg <= 1'b0;
                e_mc    <= 1'b0;
            end else begin
                e_rn    <= id_rn;
                e_wreg  <= id_wreg;
                e_m2reg <= id_m2reg;
                e_mc    <= id_mc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rn    <= '0;
            m_wreg  <= 1'b0;
            m_m2reg <= 1'b0;
        end else if (exemem_bubble) begin
            m_rn    <= '0;
            m_wreg  <= 1'b0;
            m_m2reg <= 1'b0;
        end else begin
            m_rn    <= e_rn;
            m_wreg  <= e_wreg;
            m_m2reg <= e_m2reg;
        end
    end

    // Watchdog sits at zero in RUN, so entering MC_WAIT always starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= '0;
        else if (state == MC_WAIT && !mc_exit)
            wd_cnt <= wd_cnt + 1'b1;
        else
            wd_cnt <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mc_err <= 1'b0;
        else if (state == MC_WAIT && wd_expired && !mc_done)
            mc_err <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (!pc_we && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
endmodule
